// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write path.
// Holds the default bus widths, the write-buffer FSM state type and the bit
// positions of the bank/row/column fields within a word address.
package sdram_pkg;

    localparam int SDRAM_DATA_W  = 16;
    localparam int SDRAM_ADDR_W  = 24;
    localparam int SDRAM_BST_W   = 10;
    localparam int SDRAM_FIFO_AW = 9;

    // Word address layout: {bank[23:22], row[21:9], col[8:0]}
    localparam int BANK_MSB = 23;
    localparam int BANK_LSB = 22;
    localparam int ROW_MSB  = 21;
    localparam int ROW_LSB  = 9;
    localparam int COL_MSB  = 8;
    localparam int COL_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with registered read data.
// Ports: clk/rst_n clock and async active-low reset; push/push_data write side
// (ignored when full); pop read side (ignored when empty), rd_data shows the
// popped word one cycle after pop; full flag; level = words stored;
// level_nxt = level after this cycle's accepted push/pop.
module sdram_sync_fifo
    import sdram_pkg::*;
#(
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int AW     = SDRAM_FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic [AW:0]       level,
    output logic [AW:0]       level_nxt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (level_r == FULL_LVL);
    assign push_ok_s = push && !full;
    // A pop on an empty FIFO is a protocol error and must not underflow.
    assign pop_ok_s  = pop && (level_r != {(AW+1){1'b0}});
    assign level     = level_r;
    assign rd_data   = rd_data_r;

    // Level after this cycle's accepted operations.
    always_comb begin
        level_nxt = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt = level_r + ONE_LVL;
            2'b01:   level_nxt = level_r - ONE_LVL;
            default: level_nxt = level_r;
        endcase
    end

    // Storage array write port (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, level and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {(AW+1){1'b0}};
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            level_r <= level_nxt;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                rd_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

endmodule

// File: rtl/sdram_wr_buf.sv
// SDRAM write-side buffer and burst requester.
// Buffers user words in a FIFO; once a full burst (or a flushed partial burst)
// is available and SDRAM init is done, raises wr_en with the burst address and
// length, streams FIFO words to the write engine on wr_ack, and advances the
// address ring [cfg_addr_min, cfg_addr_max] on wr_end.
// Ports: wr_clk/wr_rst_n clock and async active-low reset; usr_wr_* user
// valid/ready write port; usr_flush partial-burst request; cfg_* ring bounds
// and burst length; init_end SDRAM ready; wr_ack/wr_end engine handshake;
// wr_en/wr_addr/wr_bst_len burst request; wr_data word to engine;
// fifo_level words buffered.
module sdram_wr_buf
    import sdram_pkg::*;
#(
    parameter int DATA_W  = SDRAM_DATA_W,
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int BST_W   = SDRAM_BST_W,
    parameter int FIFO_AW = SDRAM_FIFO_AW
) (
    input  logic               wr_clk,
    input  logic               wr_rst_n,
    input  logic               usr_wr_valid,
    input  logic [DATA_W-1:0]  usr_wr_data,
    output logic               usr_wr_ready,
    input  logic               usr_flush,
    input  logic [ADDR_W-1:0]  cfg_addr_min,
    input  logic [ADDR_W-1:0]  cfg_addr_max,
    input  logic [BST_W-1:0]   cfg_bst_len,
    input  logic               init_end,
    input  logic               wr_ack,
    input  logic               wr_end,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [BST_W-1:0]   wr_bst_len,
    output logic [DATA_W-1:0]  wr_data,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int SUM_W = ADDR_W + 2;

    wr_state_e         state_r, state_nxt_s;
    logic              rdy_en_r;
    logic              flush_pend_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [BST_W-1:0]  len_r;
    logic              full_s;
    logic              push_s;
    logic [FIFO_AW:0]  lvl_s;
    logic [FIFO_AW:0]  lvl_nxt_s;
    logic              full_bst_s;
    logic              launch_s;
    logic              done_s;
    logic [BST_W-1:0]  launch_len_s;
    logic [SUM_W-1:0]  nxt_s;
    logic [SUM_W-1:0]  last_s;
    logic [SUM_W-1:0]  max_ext_s;
    logic              wrap_s;

    // Held low through reset and until the first clock after release.
    assign usr_wr_ready = rdy_en_r && !full_s;
    assign push_s       = usr_wr_valid && usr_wr_ready;
    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_bst_len   = len_r;
    assign fifo_level   = lvl_s;

    sdram_sync_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk       (wr_clk),
        .rst_n     (wr_rst_n),
        .push      (push_s),
        .push_data (usr_wr_data),
        .pop       (wr_ack),
        .rd_data   (wr_data),
        .full      (full_s),
        .level     (lvl_s),
        .level_nxt (lvl_nxt_s)
    );

    // Launch decisions use the post-push level so the word completing a
    // burst raises wr_en on the very next cycle.
    assign full_bst_s   = (cfg_bst_len != {BST_W{1'b0}}) && (lvl_nxt_s >= cfg_bst_len);
    assign launch_len_s = full_bst_s ? cfg_bst_len : lvl_nxt_s;

    // Ring advance: wrap if the next burst start or its last word is past max.
    assign max_ext_s = {2'b00, cfg_addr_max};
    assign nxt_s     = {2'b00, cur_addr_r} + {{(SUM_W-BST_W){1'b0}}, len_r};
    assign last_s    = nxt_s + {{(SUM_W-BST_W){1'b0}}, len_r} - {{(SUM_W-1){1'b0}}, 1'b1};
    assign wrap_s    = (nxt_s > max_ext_s) || (last_s > max_ext_s);

    // Burst FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rdy_en_r && init_end &&
                    (full_bst_s || (flush_pend_r && (lvl_nxt_s != {(FIFO_AW+1){1'b0}})))) begin
                    state_nxt_s = ST_REQ;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (wr_end) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else if (wr_ack) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_BUSY: begin
                if (wr_end) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, request outputs, address ring and flush bookkeeping.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_r      <= ST_IDLE;
            rdy_en_r     <= 1'b0;
            flush_pend_r <= 1'b0;
            wr_en_r      <= 1'b0;
            cur_addr_r   <= {ADDR_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            len_r        <= {BST_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rdy_en_r <= 1'b1;
            // wr_en follows the REQ state, so it drops the cycle after the first ack.
            wr_en_r  <= (state_nxt_s == ST_REQ);

            if (!rdy_en_r) begin
                cur_addr_r <= cfg_addr_min;
                wr_addr_r  <= cfg_addr_min;
            end else if (done_s) begin
                cur_addr_r <= wrap_s ? cfg_addr_min : nxt_s[ADDR_W-1:0];
            end else begin
                cur_addr_r <= cur_addr_r;
            end

            if (launch_s) begin
                wr_addr_r <= cur_addr_r;
                len_r     <= launch_len_s;
            end

            // A flush with nothing buffered is dropped.
            if (launch_s) begin
                flush_pend_r <= 1'b0;
            end else if (usr_flush && (lvl_nxt_s != {(FIFO_AW+1){1'b0}})) begin
                flush_pend_r <= 1'b1;
            end else begin
                flush_pend_r <= flush_pend_r;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_buf.sv
// Self-checking bench for sdram_wr_buf: a queue holds the words the DUT has
// accepted, a behavioural write engine acks/ends bursts, and the address ring
// is predicted from the ring rule applied to plain integers.
module tb_sdram_wr_buf;

    localparam int DW    = 16;
    localparam int AW    = 24;
    localparam int BW    = 10;
    localparam int FAW   = 9;
    localparam int DEPTH = 512;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          usr_wr_valid = 1'b0;
    logic [DW-1:0] usr_wr_data = '0;
    logic          usr_wr_ready;
    logic          usr_flush = 1'b0;
    logic [AW-1:0] cfg_addr_min = '0;
    logic [AW-1:0] cfg_addr_max = 24'h000007;
    logic [BW-1:0] cfg_bst_len = 10'd4;
    logic          init_end = 1'b0;
    logic          wr_ack = 1'b0;
    logic          wr_end = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_bst_len;
    logic [DW-1:0] wr_data;
    logic [FAW:0]  fifo_level;

    sdram_wr_buf dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .usr_wr_valid (usr_wr_valid),
        .usr_wr_data  (usr_wr_data),
        .usr_wr_ready (usr_wr_ready),
        .usr_flush    (usr_flush),
        .cfg_addr_min (cfg_addr_min),
        .cfg_addr_max (cfg_addr_max),
        .cfg_bst_len  (cfg_bst_len),
        .init_end     (init_end),
        .wr_ack       (wr_ack),
        .wr_end       (wr_end),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_bst_len   (wr_bst_len),
        .wr_data      (wr_data),
        .fifo_level   (fifo_level)
    );

    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    longint        exp_addr;
    int            exp_len;
    bit            eng_busy = 1'b0;
    int            eng_len;
    int            eng_acks;
    bit            data_pend = 1'b0;
    logic [DW-1:0] exp_word;
    bit            en_drop_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic longint ring_next(input longint a, input int len);
        longint n;
        n = a + len;
        if (n > longint'(cfg_addr_max) || n + len - 1 > longint'(cfg_addr_max))
            return longint'(cfg_addr_min);
        return n;
    endfunction

    task automatic clk_step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        eng_busy    = 1'b0;
        data_pend   = 1'b0;
        en_drop_chk = 1'b0;
        exp_addr    = longint'(cfg_addr_min);
    endtask

    // One clock of checking plus user/engine stimulus.
    task automatic tick(input int push_pct, input int ack_pct, input bit flush);
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("usr_wr_ready", 32'(usr_wr_ready), 32'(q.size() != DEPTH));
        if (data_pend) begin
            check("wr_data", 32'(wr_data), 32'(exp_word));
            data_pend = 1'b0;
        end
        if (en_drop_chk) begin
            check("wr_en_drop", 32'(wr_en), 32'd0);
            en_drop_chk = 1'b0;
        end
        usr_flush    = flush;
        usr_wr_valid = ($urandom_range(99) < push_pct);
        usr_wr_data  = DW'($urandom);
        if (usr_wr_valid && usr_wr_ready) q.push_back(usr_wr_data);
        wr_ack = 1'b0;
        wr_end = 1'b0;
        if (!eng_busy && wr_en) begin
            check("wr_addr", 32'(wr_addr), 32'(exp_addr));
            check("wr_bst_len", 32'(wr_bst_len), 32'(exp_len));
            eng_busy = 1'b1;
            eng_len  = exp_len;
            eng_acks = 0;
        end
        if (eng_busy) begin
            if (eng_acks < eng_len) begin
                if ($urandom_range(99) < ack_pct) begin
                    wr_ack    = 1'b1;
                    exp_word  = q.pop_front();
                    data_pend = 1'b1;
                    if (eng_acks == 0) en_drop_chk = 1'b1;
                    eng_acks++;
                end
            end else begin
                wr_end   = 1'b1;
                eng_busy = 1'b0;
                exp_addr = ring_next(exp_addr, eng_len);
            end
        end
        clk_step();
        usr_flush = 1'b0;
    endtask

    // Run until every buffered word has been sent, flushing any remainder.
    task automatic drain();
        int n = 0;
        exp_len = int'(cfg_bst_len);
        while ((eng_busy || q.size() >= int'(cfg_bst_len)) && n < 5000) begin
            tick(0, 80, 1'b0);
            n++;
        end
        if (q.size() > 0 && n < 5000) begin
            exp_len = q.size();
            tick(0, 80, 1'b1);
            while ((eng_busy || q.size() > 0) && n < 5000) begin
                tick(0, 80, 1'b0);
                n++;
            end
        end
        check("drain_timeout", 32'(n < 5000), 32'd1);
        tick(0, 80, 1'b0);
        exp_len = int'(cfg_bst_len);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) tick(100, 100, 1'b0);
    endtask

    initial begin
        // Reset state
        clk_step();
        clk_step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_ready", 32'(usr_wr_ready), 32'd0);
        model_reset();
        init_end = 1'b1;
        wr_rst_n = 1'b1;
        clk_step();
        exp_len = 4;

        // Minimum launch latency, then ring 0x0 -> 0x4 -> 0x0
        push_n(4);
        check("launch_latency", 32'(wr_en), 32'd1);
        drain();
        push_n(4);
        drain();
        push_n(4);
        drain();
        check("ring_wrap_state", 32'(exp_addr), 32'h4);

        // Partial burst by flush
        push_n(3);
        exp_len = 3;
        tick(0, 100, 1'b1);
        drain();
        // Flush on empty FIFO must be dropped, even after later pushes
        tick(0, 100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("empty_flush_no_en", 32'(wr_en), 32'd0);
            tick(0, 100, 1'b0);
        end
        push_n(2);
        for (int i = 0; i < 6; i++) begin
            check("stale_flush_no_en", 32'(wr_en), 32'd0);
            tick(0, 100, 1'b0);
        end
        drain();

        // Randomized segments with new ring/length configuration
        for (int s = 0; s < 3; s++) begin
            cfg_addr_min = AW'($urandom_range(1000));
            cfg_addr_max = cfg_addr_min + AW'($urandom_range(200, 16));
            cfg_bst_len  = BW'($urandom_range(16, 1));
            exp_len      = int'(cfg_bst_len);
            for (int i = 0; i < 300; i++) tick(60, 70, 1'b0);
            drain();
        end

        // Fill to capacity while SDRAM is not ready
        cfg_addr_min = 24'h000000;
        cfg_addr_max = 24'h00FFFF;
        cfg_bst_len  = 10'd8;
        exp_len      = 8;
        init_end     = 1'b0;
        for (int i = 0; i < DEPTH + 20; i++) tick(100, 100, 1'b0);
        check("full_ready", 32'(usr_wr_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'(DEPTH));
        init_end = 1'b1;
        for (int i = 0; i < 200; i++) tick(100, 100, 1'b0);
        drain();

        // Reset during BUSY clears everything on the same cycle
        cfg_addr_max = 24'h000007;
        cfg_bst_len  = 10'd4;
        exp_len      = 4;
        push_n(6);
        begin
            int n = 0;
            while (!(eng_busy && eng_acks >= 2) && n < 100) begin
                tick(0, 100, 1'b0);
                n++;
            end
            check("busy_timeout", 32'(n < 100), 32'd1);
        end
        wr_rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        usr_wr_valid = 1'b0;
        wr_ack       = 1'b0;
        wr_end       = 1'b0;
        clk_step();
        model_reset();
        wr_rst_n = 1'b1;
        clk_step();
        push_n(4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_wr_buf.md
Name: sdram_wr_buf

Overview:
Write-side buffer and burst requester directly upstream of the SDRAM write-burst engine. It accepts user write words over a valid/ready interface into a synchronous FIFO. When a full burst is buffered, it issues a write request with a bank/row/column address and burst length, then streams data to the write engine as that engine acknowledges each beat. It advances the SDRAM address ring between configurable min/max bounds after every completed burst.

Parameters:
DATA_W, 16, data word width
ADDR_W, 24, SDRAM word address width {bank[23:22], row[21:9], col[8:0]}
BST_W, 10, burst-length width
FIFO_AW, 9, FIFO address width (depth 512 words)

Ports:
wr_clk  in  1  single clock
wr_rst_n  in  1  asynchronous active-low reset
usr_wr_valid  in  1  user word valid
usr_wr_data  in  DATA_W  user word
usr_wr_ready  out  1  FIFO not full
usr_flush  in  1  pulse: request a partial burst for whatever is buffered
cfg_addr_min  in  ADDR_W  ring start address
cfg_addr_max  in  ADDR_W  ring last address (inclusive)
cfg_bst_len  in  BST_W  nominal burst length, 1..512
init_end  in  1  SDRAM init complete
wr_ack  in  1  write engine beat acknowledge (pop request)
wr_end  in  1  write engine burst-complete pulse
wr_en  out  1  burst request to write engine
wr_addr  out  ADDR_W  burst start address
wr_bst_len  out  BST_W  burst length of current request
wr_data  out  DATA_W  registered FIFO read data
fifo_level  out  FIFO_AW+1  words buffered

Behaviour:
- Reset values: usr_wr_ready 0 while in reset, 1 afterwards; wr_en 0; wr_addr = cfg_addr_min sampled on the first post-reset cycle (internal pointer held at 0 during reset); wr_bst_len 0; wr_data 0; fifo_level 0; FIFO pointers 0; FSM IDLE; flush_pend 0.
- FIFO: push when usr_wr_valid && usr_wr_ready; usr_wr_ready = (level != 2^FIFO_AW). Pop when wr_ack. wr_data is registered: a pop at cycle t presents the popped word on wr_data at t+1, matching the write engine, which samples data one cycle after ack. Simultaneous push+pop leaves the level unchanged. A pop with the FIFO empty is ignored (protocol error; level must not underflow).
- flush_pend: set by usr_flush and cleared when a burst is launched. A flush arriving with the FIFO empty is dropped.
- FSM states:
  - IDLE: launch when init_end && ((level >= cfg_bst_len && cfg_bst_len != 0) || (flush_pend && level != 0)). On launch, latch len = full ? cfg_bst_len : level, latch addr = cur_addr, then go to REQ.
  - REQ: wr_en = 1, wr_addr/wr_bst_len hold the latched values. On the first wr_ack, drop wr_en the next cycle and go to BUSY. wr_en must never be high when the engine returns to its idle state, or the engine would issue a duplicate burst.
  - BUSY: count acks. On wr_end, go to IDLE and update cur_addr.
- Address update: nxt = cur_addr + len. If nxt > cfg_addr_max, or nxt + len - 1 > cfg_addr_max, then cur_addr = cfg_addr_min; else cur_addr = nxt. Compute with an ADDR_W+1 carry bit.
- Minimum latency: a word completing a burst on cycle t gives IDLE→REQ on t+1, with wr_en high from t+1.
- Ack count mismatch: if the ack count at wr_end != len, the FSM still returns to IDLE. Verification flags this as an error.
- cfg_* changes: take effect only at the next launch.
- Reset asserted mid-burst: all state clears immediately and buffered data is discarded.

Decomposition:
- Shared package sdram_pkg: ADDR_W, DATA_W, BST_W defaults; bank/row/col field bit positions.
- Sub-module sdram_sync_fifo: single-clock FIFO with registered read data, push/pop/full/empty/level.
- The FSM, address ring and flush logic stay in sdram_wr_buf.

Test Plan:
1. Reset → wr_en=0, fifo_level=0, wr_data=0. Release reset, cfg_bst_len=4, push 4 words A0..A3 with init_end=1 → wr_en=1 one cycle after the 4th push, wr_addr=cfg_addr_min=0x000000, wr_bst_len=4.
2. Model engine: ack 4 cycles then wr_end → wr_data shows A0..A3 on the cycles after each ack. wr_en drops after the first ack. Next wr_addr=0x000004.
3. Ring wrap: min=0x000000, max=0x000007, len=4, run 3 bursts → addresses 0x0, 0x4, 0x0.
4. Flush: push 3 words, pulse usr_flush → wr_bst_len=3. Flush with an empty FIFO → no wr_en.
5. Fill 512 words with init_end=0 → usr_wr_ready=0 and further pushes ignored. Then assert init_end with push+pop concurrent → level constant and data order preserved.
6. Assert reset during BUSY → wr_en=0, fifo_level=0 on the same cycle. Normal burst after release.
